// File: rtl/regfile_write_arbiter_if.sv
// Writeback request channel: one requester presents a destination register and
// its data, and holds them until the arbiter answers with ready.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  // Requester side: drives the request, observes the grant.
  modport master (
    output valid,
    output addr,
    output data,
    input  ready
  );

  // Arbiter side: observes the request, drives the grant.
  modport slave (
    input  valid,
    input  addr,
    input  data,
    output ready
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between two writeback requesters
// (A = ALU, B = load / multi-cycle unit) with round-robin arbitration, and keeps
// a busy scoreboard of reserved destinations for RAW hazard detection in decode.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_write_arbiter_if.slave a_if,
  regfile_write_arbiter_if.slave b_if,
  input  logic                   rsv_valid,
  input  logic [ADDR_W-1:0]      rsv_addr,
  input  logic [ADDR_W-1:0]      ra,
  input  logic [ADDR_W-1:0]      rb,
  output logic                   ra_busy,
  output logic                   rb_busy,
  output logic                   RegWrite,
  output logic [ADDR_W-1:0]      rc,
  output logic [DATA_W-1:0]      dc,
  output logic                   last_grant
);

  localparam logic [NREG-1:0] ONE_HOT_0 = {{(NREG-1){1'b0}}, 1'b1};

  logic              a_ready_s;
  logic              b_ready_s;
  logic              hs_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_data_s;
  logic [NREG-1:0]   set_mask_s;
  logic [NREG-1:0]   clr_mask_s;

  logic              regwrite_d,   regwrite_q;
  logic [ADDR_W-1:0] rc_d,         rc_q;
  logic [DATA_W-1:0] dc_d,         dc_q;
  logic              last_grant_d, last_grant_q;
  logic [NREG-1:0]   busy_d,       busy_q;

  // Round-robin grant: on contention the side that did not win last time goes.
  always_comb begin
    a_ready_s = 1'b0;
    b_ready_s = 1'b0;
    if (!rst_n) begin
      a_ready_s = 1'b0;
      b_ready_s = 1'b0;
    end else if (a_if.valid && b_if.valid) begin
      if (last_grant_q) begin
        a_ready_s = 1'b1;
      end else begin
        b_ready_s = 1'b1;
      end
    end else begin
      a_ready_s = a_if.valid;
      b_ready_s = b_if.valid;
    end
  end

  // Next-state for the output stage and the scoreboard; a reservation wins
  // over a same-edge clear so the newer producer keeps the register busy.
  always_comb begin
    hs_s       = a_ready_s | b_ready_s;
    win_addr_s = a_ready_s ? a_if.addr : b_if.addr;
    win_data_s = a_ready_s ? a_if.data : b_if.data;
    set_mask_s = (rsv_valid && (rsv_addr != {ADDR_W{1'b0}})) ? (ONE_HOT_0 << rsv_addr)
                                                             : {NREG{1'b0}};
    clr_mask_s = hs_s ? (ONE_HOT_0 << win_addr_s) : {NREG{1'b0}};
    busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~ONE_HOT_0;
    regwrite_d   = 1'b0;
    rc_d         = rc_q;
    dc_d         = dc_q;
    last_grant_d = last_grant_q;
    if (hs_s) begin
      // Register 0 is hard-wired zero: the slot is consumed but nothing is written.
      regwrite_d   = (win_addr_s != {ADDR_W{1'b0}});
      rc_d         = win_addr_s;
      dc_d         = win_data_s;
      last_grant_d = b_ready_s;
    end else begin
      regwrite_d   = 1'b0;
      rc_d         = rc_q;
      dc_d         = dc_q;
      last_grant_d = last_grant_q;
    end
  end

  // State registers with synchronous active-low reset; A has first priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regwrite_q   <= 1'b0;
      rc_q         <= {ADDR_W{1'b0}};
      dc_q         <= {DATA_W{1'b0}};
      last_grant_q <= 1'b1;
      busy_q       <= {NREG{1'b0}};
    end else begin
      regwrite_q   <= regwrite_d;
      rc_q         <= rc_d;
      dc_q         <= dc_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
    end
  end

  assign a_if.ready = a_ready_s;
  assign b_if.ready = b_ready_s;
  assign RegWrite   = regwrite_q;
  assign rc         = rc_q;
  assign dc         = dc_q;
  assign last_grant = last_grant_q;
  assign ra_busy    = busy_q[ra];
  assign rb_busy    = busy_q[rb];

endmodule
